trace_fifo: RTL and testbench
=============================

Name: trace_fifo

Overview:
- Parametrised successor to the single-port trace buffer. Fully synchronous FIFO for trace_output records between the trace generator and the trace consumer or debug readout.
- Adds:
  - valid/ready output handshake
  - selectable overflow policy (overwrite-oldest or drop-newest)
  - occupancy and threshold flags
  - saturating overflow counter
  - synchronous flush
- All state updates occur on the rising edge of clk; there are no negedge or async-edge processes.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- OVERFLOW_MODE, TRACE_OVF_OVERWRITE, policy when full: TRACE_OVF_OVERWRITE discards the oldest entry, TRACE_OVF_DROP discards the incoming entry.
- ALMOST_FULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH.
- OVF_CNT_WIDTH, 16, width of the saturating overflow counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- ready_signal, input, 1, write strobe: trace_element_in is valid this cycle.
- trace_element_in, input, trace_output, record to enqueue.
- flush, input, 1, synchronous clear of contents.
- data_request, input, 1, consumer ready (pop when data_present is also 1).
- data_present, output, 1, out valid: FIFO non-empty.
- trace_element_out, output, trace_output, head-of-queue record (first-word fall-through).
- count, output, $clog2(DEPTH)+1, current occupancy.
- full, output, 1, count == DEPTH.
- almost_full, output, 1, count >= ALMOST_FULL_THRESH.
- overflow_pulse, output, 1, one-cycle pulse when an entry is lost.
- overflow_count, output, OVF_CNT_WIDTH, total entries lost; saturates at all-ones.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr, rd_ptr and count cleared to 0.
  - data_present, full, almost_full and overflow_pulse = 0.
  - overflow_count = 0.
  - trace_element_out = '0.
  - Storage contents are not cleared.
  - rst overrides flush, push and pop in the same cycle.
- Pointers:
  - $clog2(DEPTH) bits each; wrap by natural overflow.
  - No signed or -1 sentinel encoding; empty/full are derived solely from count.
- Output path:
  - trace_element_out = mem[rd_ptr] whenever count>0, otherwise '0. This is combinational from registered state.
  - data_present = (count != 0).
- Latency: a push at edge N makes data_present=1 and the record visible on trace_element_out after edge N. Write-to-read latency is 1 cycle.
- Pop: occurs at a posedge where data_request && data_present. rd_ptr is incremented and count decremented. data_request while empty is ignored.
- Push when not full: mem[wr_ptr] is written, wr_ptr is incremented, count is incremented.
- Simultaneous push and pop, non-empty: both performed and count unchanged. This includes the full case, which is not an overflow.
- Simultaneous push and pop, empty: the pop is ignored and the push is performed, so count becomes 1.
- Push when full with no pop:
  - OVERWRITE mode: write at wr_ptr, increment both wr_ptr and rd_ptr, count stays DEPTH.
  - DROP mode: record discarded, pointers unchanged.
  - Both modes: overflow_pulse=1 for that cycle; overflow_count incremented unless saturated.
- Flush:
  - Pointers and count go to 0 next cycle; overflow_count is preserved.
  - Any push or pop in the same cycle is discarded, with no overflow pulse.
- Flags: full, almost_full and data_present are registered-state derived and glitch-free. They reflect count after the edge.
- overflow_pulse is registered and high exactly one cycle per lost entry.
- Assertions:
  - count <= DEPTH at all times.
  - DEPTH is a power of two (elaboration check).
  - ALMOST_FULL_THRESH is within 1..DEPTH.

Decomposition:
- Shared package ryuki_datatypes (existing) supplies trace_output.
- Add trace_ovf_mode_e (TRACE_OVF_OVERWRITE, TRACE_OVF_DROP) to the same package so producers and configuration share it.
- One natural sub-module: trace_fifo_mem. It is a DEPTH x trace_output register array with one synchronous write port and one asynchronous read port, and no reset on its contents.
- Pointer, count, flag and counter logic stay in trace_fifo.

Test Plan:
- DEPTH=4: reset, push records A,B,C on consecutive cycles, then hold data_request=1 -> data_present rises 1 cycle after A's push; outputs A,B,C in order; count 1,2,3,2,1,0; data_present falls after the third pop.
- DEPTH=4, OVERWRITE: push 6 records R0..R5 with no pops -> full after R3; overflow_pulse on R4 and R5; overflow_count=2; drain yields R2,R3,R4,R5.
- DEPTH=4, DROP: same stimulus -> overflow_count=2; drain yields R0,R1,R2,R3.
- Full FIFO with push and data_request in the same cycle -> no overflow_pulse; count stays 4; head advances by one; new record is last out.
- Count=3 with flush, push and data_request in the same cycle -> next cycle count=0, data_present=0, overflow_count unchanged; a subsequent single push returns that record.
- OVF_CNT_WIDTH=2, DROP, 5 overflowing pushes -> overflow_count sticks at 3; mid-stream rst -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the trace path: the trace record format and the
// overflow policy selector used by trace producers and their buffers.
package ryuki_datatypes;

   typedef struct packed {
      logic [3:0]  kind;
      logic [31:0] addr;
      logic [15:0] data;
   } trace_output;

   typedef enum logic {
      TRACE_OVF_OVERWRITE = 1'b0,
      TRACE_OVF_DROP      = 1'b1
   } trace_ovf_mode_e;

endpackage

// File: rtl/trace_fifo_mem.sv
// Storage array for trace_fifo: one synchronous write port, one
// asynchronous read port, contents are deliberately left unreset.
module trace_fifo_mem
   import ryuki_datatypes::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  trace_output      wdata,
   input  logic [PTR_W-1:0] raddr,
   output trace_output      rdata
);

   trace_output mem [DEPTH];

   // Write the incoming record into its slot; no reset keeps this a plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trace_fifo.sv
// First-word fall-through trace FIFO with valid/ready output handshake,
// selectable overflow policy, occupancy flags, a saturating lost-entry
// counter and synchronous flush. Empty/full are derived only from count.
module trace_fifo
   import ryuki_datatypes::*;
#(
   parameter int unsigned     DEPTH              = 8,
   parameter trace_ovf_mode_e OVERFLOW_MODE      = TRACE_OVF_OVERWRITE,
   parameter int unsigned     ALMOST_FULL_THRESH = DEPTH - 2,
   parameter int unsigned     OVF_CNT_WIDTH      = 16,
   localparam int unsigned    PTR_W              = $clog2(DEPTH),
   localparam int unsigned    CNT_W              = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ready_signal,
   input  trace_output              trace_element_in,
   input  logic                     flush,
   input  logic                     data_request,
   output logic                     data_present,
   output trace_output              trace_element_out,
   output logic [CNT_W-1:0]         count,
   output logic                     full,
   output logic                     almost_full,
   output logic                     overflow_pulse,
   output logic [OVF_CNT_WIDTH-1:0] overflow_count
);

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALMOST_FULL_THRESH);

   // Reject configurations the pointer arithmetic cannot support.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("trace_fifo: DEPTH must be a power of two and at least 2");
   end
   if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_thresh
      $error("trace_fifo: ALMOST_FULL_THRESH must lie in 1..DEPTH");
   end

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic             mem_we;
   trace_output      head;

   assign push = ready_signal;
   assign pop  = data_request && data_present;

   // A write lands in storage unless flush/reset kill it, or the FIFO is full
   // in drop mode with no pop to make room.
   assign mem_we = push && !flush && !rst &&
                   (pop || !full || (OVERFLOW_MODE == TRACE_OVF_OVERWRITE));

   trace_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (trace_element_in),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign data_present      = (count != '0);
   assign full              = (count == DEPTH_C);
   assign almost_full       = (count >= THRESH_C);
   assign trace_element_out = data_present ? head : '0;

   // Pointer, occupancy and overflow bookkeeping; reset beats flush beats traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow_pulse <= 1'b0;
         overflow_count <= '0;
      end else if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         overflow_pulse <= 1'b0;
      end else begin
         overflow_pulse <= 1'b0;
         if (push && pop) begin
            wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
         end else if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end else if (push) begin
            overflow_pulse <= 1'b1;
            if (!(&overflow_count)) begin
               overflow_count <= overflow_count + 1'b1;
            end
            if (OVERFLOW_MODE == TRACE_OVF_OVERWRITE) begin
               wr_ptr <= wr_ptr + 1'b1;
               rd_ptr <= rd_ptr + 1'b1;
            end
         end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   // Occupancy can never exceed the number of storage slots.
   a_count_bound : assert property (@(posedge clk) count <= DEPTH_C);

endmodule

// File: tb/tb_trace_fifo.sv
// Directed bench for trace_fifo: three DEPTH=4 instances (overwrite, drop,
// drop with a 2-bit overflow counter) share one stimulus stream.
module tb_trace_fifo;
   import ryuki_datatypes::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready_signal;
   trace_output trace_element_in;
   logic        flush;
   logic        data_request;

   logic        ovw_dp, drp_dp, sat_dp;
   trace_output ovw_out, drp_out, sat_out;
   logic [2:0]  ovw_cnt, drp_cnt, sat_cnt;
   logic        ovw_full, drp_full, sat_full;
   logic        ovw_af, drp_af, sat_af;
   logic        ovw_pulse, drp_pulse, sat_pulse;
   logic [15:0] ovw_ovf, drp_ovf;
   logic [1:0]  sat_ovf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trace_fifo #(.DEPTH(4), .OVERFLOW_MODE(TRACE_OVF_OVERWRITE), .OVF_CNT_WIDTH(16)) u_ovw (
      .clk(clk), .rst(rst), .ready_signal(ready_signal), .trace_element_in(trace_element_in),
      .flush(flush), .data_request(data_request), .data_present(ovw_dp),
      .trace_element_out(ovw_out), .count(ovw_cnt), .full(ovw_full), .almost_full(ovw_af),
      .overflow_pulse(ovw_pulse), .overflow_count(ovw_ovf));

   trace_fifo #(.DEPTH(4), .OVERFLOW_MODE(TRACE_OVF_DROP), .OVF_CNT_WIDTH(16)) u_drp (
      .clk(clk), .rst(rst), .ready_signal(ready_signal), .trace_element_in(trace_element_in),
      .flush(flush), .data_request(data_request), .data_present(drp_dp),
      .trace_element_out(drp_out), .count(drp_cnt), .full(drp_full), .almost_full(drp_af),
      .overflow_pulse(drp_pulse), .overflow_count(drp_ovf));

   trace_fifo #(.DEPTH(4), .OVERFLOW_MODE(TRACE_OVF_DROP), .OVF_CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .ready_signal(ready_signal), .trace_element_in(trace_element_in),
      .flush(flush), .data_request(data_request), .data_present(sat_dp),
      .trace_element_out(sat_out), .count(sat_cnt), .full(sat_full), .almost_full(sat_af),
      .overflow_pulse(sat_pulse), .overflow_count(sat_ovf));

   // Build a distinguishable record from a small id.
   function automatic trace_output rec(input int n);
      trace_output r;
      r.kind = 4'(n);
      r.addr = 32'h1000_0000 + 32'(n);
      r.data = 16'hA500 + 16'(n);
      return r;
   endfunction

   // Drive one cycle of inputs, then settle 1 time unit past the edge.
   task automatic applyStimulus(input logic r, input logic psh, input int id,
                                input logic drq, input logic fl);
      rst              = r;
      ready_signal     = psh;
      trace_element_in = psh ? rec(id) : '0;
      data_request     = drq;
      flush            = fl;
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; ready_signal = 1'b0; trace_element_in = '0;
      data_request = 1'b0; flush = 1'b0;
      #2;

      // Reset state
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rst_count", 64'(ovw_cnt), 64'd0);
      checkOutput("rst_dp", 64'(ovw_dp), 64'd0);
      checkOutput("rst_out", 64'(ovw_out), 64'd0);
      checkOutput("rst_ovf", 64'(ovw_ovf), 64'd0);
      checkOutput("rst_full", 64'(drp_full), 64'd0);

      // Push A,B,C then drain with data_request held
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("a_dp", 64'(ovw_dp), 64'd1);
      checkOutput("a_head", 64'(ovw_out), 64'(rec(1)));
      checkOutput("a_count", 64'(ovw_cnt), 64'd1);
      checkOutput("a_af", 64'(ovw_af), 64'd0);
      applyStimulus(0, 1, 2, 0, 0);
      checkOutput("b_count", 64'(ovw_cnt), 64'd2);
      checkOutput("b_af", 64'(ovw_af), 64'd1);
      applyStimulus(0, 1, 3, 0, 0);
      checkOutput("c_count", 64'(ovw_cnt), 64'd3);
      checkOutput("c_head", 64'(ovw_out), 64'(rec(1)));
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("pop1_count", 64'(ovw_cnt), 64'd2);
      checkOutput("pop1_head", 64'(ovw_out), 64'(rec(2)));
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("pop2_count", 64'(ovw_cnt), 64'd1);
      checkOutput("pop2_head", 64'(ovw_out), 64'(rec(3)));
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("pop3_count", 64'(ovw_cnt), 64'd0);
      checkOutput("pop3_dp", 64'(ovw_dp), 64'd0);
      checkOutput("pop3_out", 64'(ovw_out), 64'd0);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("empty_pop_count", 64'(drp_cnt), 64'd0);

      // R0..R5 with no pops: overflow on R4 and R5
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16 + i, 0, 0);
      checkOutput("r3_full_ovw", 64'(ovw_full), 64'd1);
      checkOutput("r3_full_drp", 64'(drp_full), 64'd1);
      checkOutput("r3_pulse", 64'(ovw_pulse), 64'd0);
      applyStimulus(0, 1, 20, 0, 0);
      checkOutput("r4_pulse_ovw", 64'(ovw_pulse), 64'd1);
      checkOutput("r4_pulse_drp", 64'(drp_pulse), 64'd1);
      checkOutput("r4_count_ovw", 64'(ovw_cnt), 64'd4);
      checkOutput("r4_head_ovw", 64'(ovw_out), 64'(rec(17)));
      checkOutput("r4_head_drp", 64'(drp_out), 64'(rec(16)));
      applyStimulus(0, 1, 21, 0, 0);
      checkOutput("r5_pulse_ovw", 64'(ovw_pulse), 64'd1);
      checkOutput("r5_ovf_ovw", 64'(ovw_ovf), 64'd2);
      checkOutput("r5_ovf_drp", 64'(drp_ovf), 64'd2);
      checkOutput("r5_ovf_sat", 64'(sat_ovf), 64'd2);
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_ovw", 64'(ovw_out), 64'(rec(18 + i)));
         checkOutput("drain_drp", 64'(drp_out), 64'(rec(16 + i)));
         applyStimulus(0, 0, 0, 1, 0);
      end
      checkOutput("drain_pulse", 64'(ovw_pulse), 64'd0);
      checkOutput("drain_count", 64'(drp_cnt), 64'd0);

      // Full FIFO, push and pop together: no overflow
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32 + i, 0, 0);
      applyStimulus(0, 1, 36, 1, 0);
      checkOutput("pp_pulse_ovw", 64'(ovw_pulse), 64'd0);
      checkOutput("pp_pulse_drp", 64'(drp_pulse), 64'd0);
      checkOutput("pp_count", 64'(drp_cnt), 64'd4);
      checkOutput("pp_ovf", 64'(drp_ovf), 64'd2);
      for (int i = 0; i < 4; i++) begin
         checkOutput("pp_drain_drp", 64'(drp_out), 64'(rec(33 + i)));
         checkOutput("pp_drain_ovw", 64'(ovw_out), 64'(rec(33 + i)));
         applyStimulus(0, 0, 0, 1, 0);
      end

      // Flush with push and pop in the same cycle
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 48 + i, 0, 0);
      checkOutput("pre_flush_count", 64'(ovw_cnt), 64'd3);
      applyStimulus(0, 1, 51, 1, 1);
      checkOutput("flush_count", 64'(ovw_cnt), 64'd0);
      checkOutput("flush_dp", 64'(drp_dp), 64'd0);
      checkOutput("flush_ovf", 64'(ovw_ovf), 64'd2);
      checkOutput("flush_pulse", 64'(ovw_pulse), 64'd0);
      applyStimulus(0, 1, 52, 0, 0);
      checkOutput("post_flush_count", 64'(ovw_cnt), 64'd1);
      checkOutput("post_flush_head", 64'(ovw_out), 64'(rec(52)));
      applyStimulus(0, 0, 0, 1, 0);

      // Counter saturation from a clean reset
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("sat_rst_ovf", 64'(sat_ovf), 64'd0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 64 + i, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 68 + i, 0, 0);
      checkOutput("sat_ovf", 64'(sat_ovf), 64'd3);
      checkOutput("sat_pulse", 64'(sat_pulse), 64'd1);
      checkOutput("sat_drp_ovf", 64'(drp_ovf), 64'd5);
      checkOutput("sat_head", 64'(sat_out), 64'(rec(64)));

      // Mid-stream reset overriding push and pop
      applyStimulus(1, 1, 80, 1, 0);
      checkOutput("mrst_count", 64'(sat_cnt), 64'd0);
      checkOutput("mrst_full", 64'(sat_full), 64'd0);
      checkOutput("mrst_af", 64'(sat_af), 64'd0);
      checkOutput("mrst_dp", 64'(sat_dp), 64'd0);
      checkOutput("mrst_pulse", 64'(sat_pulse), 64'd0);
      checkOutput("mrst_ovf", 64'(sat_ovf), 64'd0);
      checkOutput("mrst_out", 64'(sat_out), 64'd0);
      checkOutput("mrst_ovw_count", 64'(ovw_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
